// File: rtl/sort_fsm_pkg.sv
// Shared types and helpers for the FSM-sequenced floating-point sorter.
// FLEN is the project-wide floating-point width (FP64).
package sort_fsm_pkg;

   localparam int FLEN = 64;

   typedef enum logic [0:0] {IDLE, SORT} sort_state_t;

   function automatic int num_compares(input int n);
      return n * (n - 1) / 2;
   endfunction

endpackage

// File: rtl/sort_n_floats_using_fsm.sv
// Bubble-sorts N floats using one external combinational f_less_or_equal, one compare per cycle.
// Optional SORT_FSM_EARLY_EXIT_EN: finish as soon as a full pass performs no swap.
module sort_n_floats_using_fsm
   import sort_fsm_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      valid_in,
   input  logic [0:N-1][FLEN-1:0]    unsorted,
   output logic                      valid_out,
   output logic [0:N-1][FLEN-1:0]    sorted,
   output logic                      err,
   output logic                      busy,
   output logic [FLEN-1:0]           f_le_a,
   output logic [FLEN-1:0]           f_le_b,
   input  logic                      f_le_res,
   input  logic                      f_le_err
);

   // Handshake: valid_in is sampled only while busy==0 (IDLE); valid_out is a
   // one-cycle pulse qualifying err and a freshly written sorted, which then holds.
   localparam int CW = ($clog2(N) < 1) ? 1 : $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 2);

   sort_state_t              state_q, state_d;
   logic [0:N-1][FLEN-1:0]   arr_q, arr_d;
   logic [0:N-1][FLEN-1:0]   sorted_q, sorted_d;
   logic [CW-1:0]            pass_q, pass_d;
   logic [CW-1:0]            j_q, j_d;
   logic [CW-1:0]            j_nxt;
   logic                     valid_out_q, valid_out_d;
   logic                     err_q, err_d;
   logic                     done;
`ifdef SORT_FSM_EARLY_EXIT_EN
   logic                     swapped_q, swapped_d;
`endif

   assign j_nxt     = j_q + CW'(1);
   assign busy      = (state_q != IDLE);
   assign valid_out = valid_out_q;
   assign err       = err_q;
   assign sorted    = sorted_q;

   always_comb begin
      state_d     = state_q;
      arr_d       = arr_q;
      sorted_d    = sorted_q;
      pass_d      = pass_q;
      j_d         = j_q;
      valid_out_d = 1'b0;
      err_d       = 1'b0;
      done        = 1'b0;
      f_le_a      = '0;
      f_le_b      = '0;
`ifdef SORT_FSM_EARLY_EXIT_EN
      swapped_d   = swapped_q;
`endif
      case (state_q)
         IDLE: begin
            if (valid_in) begin
               arr_d   = unsorted;
               pass_d  = '0;
               j_d     = '0;
               state_d = SORT;
`ifdef SORT_FSM_EARLY_EXIT_EN
               swapped_d = 1'b0;
`endif
            end
         end
         SORT: begin
            f_le_a = arr_q[j_q];
            f_le_b = arr_q[j_nxt];
            if (f_le_err) begin
               // An invalid operand aborts the sort; the partially sorted array is reported.
               sorted_d    = arr_q;
               err_d       = 1'b1;
               valid_out_d = 1'b1;
               state_d     = IDLE;
            end else begin
               if (!f_le_res) begin
                  arr_d[j_q]   = arr_q[j_nxt];
                  arr_d[j_nxt] = arr_q[j_q];
               end
               if (j_q == LAST - pass_q) begin
                  j_d    = '0;
                  pass_d = pass_q + CW'(1);
                  done   = (pass_q == LAST);
`ifdef SORT_FSM_EARLY_EXIT_EN
                  if (!swapped_q && f_le_res) done = 1'b1;
                  swapped_d = 1'b0;
`endif
                  if (done) begin
                     sorted_d    = arr_d;
                     valid_out_d = 1'b1;
                     state_d     = IDLE;
                  end
               end else begin
                  j_d = j_nxt;
`ifdef SORT_FSM_EARLY_EXIT_EN
                  swapped_d = swapped_q | !f_le_res;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         arr_q       <= '0;
         sorted_q    <= '0;
         pass_q      <= '0;
         j_q         <= '0;
         valid_out_q <= 1'b0;
         err_q       <= 1'b0;
`ifdef SORT_FSM_EARLY_EXIT_EN
         swapped_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         arr_q       <= arr_d;
         sorted_q    <= sorted_d;
         pass_q      <= pass_d;
         j_q         <= j_d;
         valid_out_q <= valid_out_d;
         err_q       <= err_d;
`ifdef SORT_FSM_EARLY_EXIT_EN
         swapped_q   <= swapped_d;
`endif
      end
   end

endmodule

// File: tb/tb_sort_n_floats_using_fsm.sv
// Directed bench for sort_n_floats_using_fsm (N=4 and N=3 instances) with an FP64 compare model.
module tb_sort_n_floats_using_fsm;
   import sort_fsm_pkg::*;

   typedef logic [0:3][63:0] vec4_t;
   typedef logic [0:2][63:0] vec3_t;

   localparam logic [63:0] P3  = 64'h4008_0000_0000_0000;
   localparam logic [63:0] P2  = 64'h4000_0000_0000_0000;
   localparam logic [63:0] P1  = 64'h3FF0_0000_0000_0000;
   localparam logic [63:0] M1  = 64'hBFF0_0000_0000_0000;
   localparam logic [63:0] NAN = 64'h7FF8_0000_0000_0000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // N=4 instance
   logic        valid_in4, valid_out4, err4, busy4, le_res4, le_err4;
   vec4_t       unsorted4, sorted4;
   logic [63:0] f_le_a4, f_le_b4;
   // N=3 instance
   logic        valid_in3, valid_out3, err3, busy3, le_res3, le_err3;
   vec3_t       unsorted3, sorted3;
   logic [63:0] f_le_a3, f_le_b3;

   int err_cnt = 0;
   int chk_cnt = 0;
   logic [255:0] exp_q[$];

   // FP64 a <= b; err on any NaN operand; +0 and -0 compare equal.
   function automatic logic [1:0] fle(input logic [63:0] a, input logic [63:0] b);
      logic a_nan, b_nan, le;
      a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
      b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
      if ((a[62:0] == 63'd0) && (b[62:0] == 63'd0)) le = 1'b1;
      else if (a[63] != b[63])                    le = a[63];
      else if (!a[63])                            le = (a[62:0] <= b[62:0]);
      else                                        le = (a[62:0] >= b[62:0]);
      return {a_nan | b_nan, le};
   endfunction

   assign {le_err4, le_res4} = fle(f_le_a4, f_le_b4);
   assign {le_err3, le_res3} = fle(f_le_a3, f_le_b3);

   sort_n_floats_using_fsm #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in4), .unsorted(unsorted4),
      .valid_out(valid_out4), .sorted(sorted4), .err(err4), .busy(busy4),
      .f_le_a(f_le_a4), .f_le_b(f_le_b4), .f_le_res(le_res4), .f_le_err(le_err4)
   );

   sort_n_floats_using_fsm #(.N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in3), .unsorted(unsorted3),
      .valid_out(valid_out3), .sorted(sorted3), .err(err3), .busy(busy3),
      .f_le_a(f_le_a3), .f_le_b(f_le_b3), .f_le_res(le_res3), .f_le_err(le_err3)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents vec at posedge+1, waits (bounded) for valid_out and checks the result.
   // glitch_at>0 raises valid_in for one cycle mid-sort; the DUT must ignore it.
   task automatic run4(input string tag, input vec4_t vec, input vec4_t exp_vec,
                       input logic exp_err, input int exp_lat, input int glitch_at);
      int    cyc;
      vec4_t vtmp;
      vtmp = vec;
      exp_q.push_back(256'(exp_vec));
      unsorted4 = vec;
      valid_in4 = 1'b1;
      @(posedge clk); #1;
      valid_in4 = 1'b0;
      check({tag, "_busy_start"}, 256'(busy4), 256'(1));
      check({tag, "_opa"}, 256'(f_le_a4), 256'(vtmp[0]));
      check({tag, "_opb"}, 256'(f_le_b4), 256'(vtmp[1]));
      cyc = 0;
      do begin
         if (glitch_at > 0 && cyc == glitch_at) begin
            unsorted4 = {P3, P2, P1, M1};
            valid_in4 = 1'b1;
         end
         @(posedge clk); #1;
         valid_in4 = 1'b0;
         cyc++;
      end while (!valid_out4 && cyc < 60);
      check({tag, "_vout"}, 256'(valid_out4), 256'(1));
      check({tag, "_lat"}, 256'(cyc), 256'(exp_lat));
      check({tag, "_err"}, 256'(err4), 256'(exp_err));
      check({tag, "_busy_end"}, 256'(busy4), 256'(0));
      check({tag, "_sorted"}, 256'(sorted4), exp_q.pop_front());
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    pulses;
      int    cyc;
      int    c4, c3, lat_sorted, lat_ones;
      vec4_t held;

      c4 = num_compares(4);
      c3 = num_compares(3);
`ifdef SORT_FSM_EARLY_EXIT_EN
      lat_sorted = 3;
      lat_ones   = 3;
`else
      lat_sorted = c4;
      lat_ones   = c4;
`endif

      rst_n = 1'b0;
      valid_in4 = 1'b0; unsorted4 = '0;
      valid_in3 = 1'b0; unsorted3 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_vout",   256'(valid_out4), 256'(0));
      check("rst_err",    256'(err4),       256'(0));
      check("rst_busy",   256'(busy4),      256'(0));
      check("rst_sorted", 256'(sorted4),    256'(0));
      check("rst_opa",    256'(f_le_a4),    256'(0));
      check("rst_opb",    256'(f_le_b4),    256'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reverse order, full latency.
      run4("rev", {P3, P2, P1, M1}, {M1, P1, P2, P3}, 1'b0, c4, 0);
      held = sorted4;
      @(posedge clk); #1;
      check("hold_vout",   256'(valid_out4), 256'(0));
      check("hold_sorted", 256'(sorted4),    256'(held));
      check("idle_opa",    256'(f_le_a4),    256'(0));

      // N=3 with equal keys.
      unsorted3 = {P2, P1, P2};
      valid_in3 = 1'b1;
      @(posedge clk); #1;
      valid_in3 = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!valid_out3 && cyc < 60);
      check("n3_vout",   256'(valid_out3), 256'(1));
      check("n3_lat",    256'(cyc),        256'(c3));
      check("n3_err",    256'(err3),       256'(0));
      check("n3_sorted", 256'(sorted3),    256'({P1, P2, P2}));

      // NaN in element 2: second compare (2.0 vs NaN) reports error, array unchanged.
      run4("nan", {P1, P2, NAN, P3}, {P1, P2, NAN, P3}, 1'b1, 2, 0);
      @(posedge clk); #1;
      check("nan_err_clear", 256'(err4), 256'(0));

      // Back-to-back: second vector raised in the first's valid_out cycle, glitch mid-sort.
      run4("b2b_a", {P2, P3, M1, P1}, {M1, P1, P2, P3}, 1'b0, c4, 0);
      run4("b2b_b", {P1, P1, P1, P1}, {P1, P1, P1, P1}, 1'b0, lat_ones, 2);
      pulses = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (valid_out4) pulses++;
      end
      check("glitch_ignored", 256'(pulses), 256'(0));
      check("glitch_busy",    256'(busy4),  256'(0));

      // Reset for one cycle mid-sort.
      unsorted4 = {P3, P2, P1, M1};
      valid_in4 = 1'b1;
      @(posedge clk); #1;
      valid_in4 = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_busy",   256'(busy4),      256'(0));
      check("abort_vout",   256'(valid_out4), 256'(0));
      check("abort_sorted", 256'(sorted4),    256'(0));
      check("abort_opa",    256'(f_le_a4),    256'(0));
      pulses = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (valid_out4) pulses++;
      end
      check("abort_no_pulse", 256'(pulses), 256'(0));
      run4("post_rst", {P2, P3, M1, P1}, {M1, P1, P2, P3}, 1'b0, c4, 0);

      // Already-sorted input.
      run4("presorted", {M1, P1, P2, P3}, {M1, P1, P2, P3}, 1'b0, lat_sorted, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
